axis_lfsr_burst_ctrl: RTL and testbench
=======================================

# axis_lfsr_burst_ctrl

Burst scheduler for the pseudo-noise excitation path. Sits between the LFSR noise source (AXI4-Stream master) and the DAC stream. On a trigger it gates a programmed number of noise beats through, inserts zero-valued gap beats, and repeats for a programmed burst count. It freezes the LFSR (deasserts tready) whenever noise is not being passed.

## Interface
- AXIS_TDATA_WIDTH, 64: stream data width, both sides.
- CNTR_WIDTH, 32: width of all length/count fields.

- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_burst_len  in  CNTR_WIDTH  noise beats per burst; 0 = trigger ignored.
- cfg_gap_len  in  CNTR_WIDTH  zero beats after each burst; 0 = no gap.
- cfg_repeat  in  CNTR_WIDTH  bursts per trigger; 0 = repeat until stop.
- trigger  in  1  rising edge starts a sequence.
- stop  in  1  level; forces return to IDLE.
- sts_busy  out  1  high when state is not IDLE.
- sts_bursts  out  CNTR_WIDTH  bursts completed in current/last sequence.
- s_axis_tready  out  1  to LFSR.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  noise data.
- s_axis_tvalid  in  1  noise valid.
- m_axis_tready  in  1  from DAC path.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output data.
- m_axis_tvalid  out  1  output valid.

## Operation
- States: IDLE, BURST, GAP. Reset: IDLE, enable flag 0, counters 0, trigger history 0.
- Enable flag sets 1 on first cycle after reset release; m_axis_tvalid = 0 while flag is 0.
- IDLE: m_axis_tvalid = enable flag, m_axis_tdata = 0, s_axis_tready = 0.
- BURST: m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready (combinational pass-through).
- GAP: m_axis_tdata = 0, m_axis_tvalid = 1, s_axis_tready = 0.
- Beat = BURST: s_axis_tvalid & m_axis_tready; GAP: m_axis_tready.
- Trigger edge: trigger = 1 and registered trigger = 0. In IDLE with cfg_burst_len != 0: latch all cfg_* into internal registers, clear beat counter and sts_bursts, go BURST. Edges in BURST/GAP or with cfg_burst_len = 0 are ignored.
- cfg_* changes after latch have no effect until the next trigger.
- BURST: beat counter increments per beat. On the beat with counter = len-1: counter clears, sts_bursts increments; next state IDLE if repeat != 0 and sts_bursts+1 = repeat, else GAP if gap != 0, else BURST.
- GAP: on the beat with counter = gap-1: counter clears, go BURST.
- stop = 1 in BURST/GAP: next state IDLE, counter clears, sts_bursts holds. A beat handshaked in that same cycle completes normally. stop has precedence over trigger and over the end-of-burst transition.
- sts_bursts wraps modulo 2^CNTR_WIDTH in continuous mode. Beat counter never exceeds len-1.

## Timing
- Trigger edge sampled in cycle N -> BURST in N+1; first noise beat may transfer in N+1.
- Last beat handshaked in cycle N -> new state and sts_bursts visible in N+1.
- Zero added latency on data: s->m path is combinational in BURST; no skid buffer.
- State, counters, sts_* and enable flag are registered. Outputs depend only on state, enable flag and the s/m handshake inputs.
- aresetn assertion mid-sequence: immediate IDLE, m_axis_tvalid = 0, s_axis_tready = 0.

## Test plan
- Reset: hold aresetn low 5 cycles -> m_tvalid = 0, s_tready = 0, sts_busy = 0, sts_bursts = 0. One cycle after release -> m_tvalid = 1, m_tdata = 0.
- burst 4, gap 0, repeat 1, m_tready = 1, trigger pulse -> exactly 4 LFSR words on m_axis, then zeros. sts_busy high 4 cycles, sts_bursts = 1.
- burst 3, gap 2, repeat 2 -> m_tdata sequence N,N,N,0,0,N,N,N then idle zeros; s_tready low during gap; sts_bursts = 2.
- Backpressure: burst 4, m_tready toggling 1,0,1,0… -> 4 noise beats transferred over 8 cycles; LFSR advances only on handshakes; no duplicated or dropped words.
- repeat 0, burst 2, gap 1, stop asserted after 7 beats -> IDLE next cycle. sts_bursts = 3 and holds; later trigger restarts and clears sts_bursts.
- Trigger during BURST ignored. Trigger with cfg_burst_len = 0 -> sts_busy stays 0.

Source files
------------

// File: rtl/axis_lfsr_burst_ctrl.sv
// Burst scheduler between the LFSR noise source and the DAC stream: gates bursts of
// noise beats, pads with zero-valued gap beats, and repeats for a programmed count.
module axis_lfsr_burst_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_burst_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_gap_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_repeat,
    input  logic                        trigger,
    input  logic                        stop,
    output logic                        sts_busy,
    output logic [CNTR_WIDTH-1:0]       sts_bursts,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_enable;
    logic                    r_trig_d;
    logic [CNTR_WIDTH-1:0]   r_cnt;
    logic [CNTR_WIDTH-1:0]   r_len;
    logic [CNTR_WIDTH-1:0]   r_gap;
    logic [CNTR_WIDTH-1:0]   r_rep;
    logic [CNTR_WIDTH-1:0]   r_bursts;

    logic                    w_beat;
    logic                    w_start;
    logic                    w_burst_last;
    logic                    w_gap_last;
    logic                    w_stop_active;
    logic [CNTR_WIDTH-1:0]   w_bursts_inc;

    assign w_beat = (r_state == ST_BURST) ? (s_axis_tvalid & m_axis_tready) :
                    (r_state == ST_GAP)   ? m_axis_tready : 1'b0;

    // A zero burst length disarms the trigger entirely.
    assign w_start       = (r_state == ST_IDLE) && trigger && !r_trig_d &&
                           (cfg_burst_len != '0);
    assign w_burst_last  = (r_state == ST_BURST) && w_beat &&
                           (r_cnt == r_len - CNTR_WIDTH'(1));
    assign w_gap_last    = (r_state == ST_GAP) && w_beat &&
                           (r_cnt == r_gap - CNTR_WIDTH'(1));
    assign w_stop_active = (r_state != ST_IDLE) && stop;
    assign w_bursts_inc  = r_bursts + CNTR_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // stop overrides the end-of-burst decision; the final beat still counts.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_burst_last) begin
                    if ((r_rep != '0) && (w_bursts_inc == r_rep)) begin
                        w_next_state = ST_IDLE;
                    end else if (r_gap != '0) begin
                        w_next_state = ST_GAP;
                    end else begin
                        w_next_state = ST_BURST;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_gap_last) begin
                    w_next_state = ST_BURST;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                m_axis_tvalid = r_enable;
            end
            ST_BURST: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
            ST_GAP: begin
                m_axis_tvalid = 1'b1;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_enable <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_enable <= 1'b1;
            r_trig_d <= trigger;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_len <= '0;
            r_gap <= '0;
            r_rep <= '0;
        end else if (w_start) begin
            r_len <= cfg_burst_len;
            r_gap <= cfg_gap_len;
            r_rep <= cfg_repeat;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt    <= '0;
            r_bursts <= '0;
        end else begin
            if (w_start || w_stop_active || w_burst_last || w_gap_last) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNTR_WIDTH'(1);
            end

            if (w_start) begin
                r_bursts <= '0;
            end else if (w_burst_last) begin
                r_bursts <= w_bursts_inc;
            end
        end
    end

    assign sts_busy   = (r_state != ST_IDLE);
    assign sts_bursts = r_bursts;

endmodule

// File: tb/tb_axis_lfsr_burst_ctrl.sv
// Directed bench for axis_lfsr_burst_ctrl: a scoreboard queue of expected m_axis words
// is filled by the stimulus and drained by a monitor on every output handshake.
module tb_axis_lfsr_burst_ctrl;

    localparam int DW = 64;
    localparam int CW = 32;

    logic          aclk;
    logic          aresetn;
    logic [CW-1:0] cfg_burst_len;
    logic [CW-1:0] cfg_gap_len;
    logic [CW-1:0] cfg_repeat;
    logic          trigger;
    logic          stop;
    logic          sts_busy;
    logic [CW-1:0] sts_bursts;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    int checks   = 0;
    int failures = 0;
    int srcIdx   = 0;
    int nextIdx  = 0;
    logic [DW-1:0] expQ[$];

    axis_lfsr_burst_ctrl #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH      (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_burst_len (cfg_burst_len),
        .cfg_gap_len   (cfg_gap_len),
        .cfg_repeat    (cfg_repeat),
        .trigger       (trigger),
        .stop          (stop),
        .sts_busy      (sts_busy),
        .sts_bursts    (sts_bursts),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [DW-1:0] wordOf(input int idx);
        return 64'hBEEF_0000_0000_0000 + 64'(idx);
    endfunction

    // Noise source stand-in: each accepted word advances the sequence index by one.
    assign s_axis_tdata = wordOf(srcIdx);
    always @(posedge aclk) begin
        if (s_axis_tvalid && s_axis_tready) begin
            srcIdx <= srcIdx + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready && expQ.size() > 0) begin
            checkOutput("m_tdata", m_axis_tdata, expQ.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pushNoise(input int n);
        repeat (n) begin
            expQ.push_back(wordOf(nextIdx));
            nextIdx++;
        end
    endtask

    task automatic pushZero(input int n);
        repeat (n) expQ.push_back('0);
    endtask

    task automatic fireTrigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    task automatic setCfg(input int len, input int gap, input int rep);
        cfg_burst_len = CW'(len);
        cfg_gap_len   = CW'(gap);
        cfg_repeat    = CW'(rep);
    endtask

    task automatic applyStimulus();
        int busyCnt;
        int startIdx;

        aresetn       = 1'b0;
        trigger       = 1'b0;
        stop          = 1'b0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        setCfg(0, 0, 0);
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst s_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("rst busy", 64'(sts_busy), 64'd0);
        checkOutput("rst bursts", 64'(sts_bursts), 64'd0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("pre-enable m_tvalid", 64'(m_axis_tvalid), 64'd0);
        tick();
        @(negedge aclk);
        checkOutput("enable m_tvalid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("enable m_tdata", m_axis_tdata, 64'd0);
        tick();

        // Single burst of four, no gap.
        setCfg(4, 0, 1);
        pushNoise(4);
        pushZero(2);
        fireTrigger();
        m_axis_tready = 1'b1;
        busyCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            busyCnt += int'(sts_busy);
            tick();
        end
        m_axis_tready = 1'b0;
        checkOutput("s1 busy cycles", 64'(busyCnt), 64'd4);
        checkOutput("s1 bursts", 64'(sts_bursts), 64'd1);
        checkDrained("s1 drained");

        // Two bursts of three separated by a two-beat gap; cfg changed after latch.
        setCfg(3, 2, 2);
        pushNoise(3);
        pushZero(2);
        pushNoise(3);
        pushZero(2);
        fireTrigger();
        m_axis_tready = 1'b1;
        setCfg(9, 0, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (i == 0) checkOutput("s2 s_tready burst", 64'(s_axis_tready), 64'd1);
            if (i == 3 || i == 4) checkOutput("s2 s_tready gap", 64'(s_axis_tready), 64'd0);
            tick();
        end
        m_axis_tready = 1'b0;
        checkOutput("s2 bursts", 64'(sts_bursts), 64'd2);
        checkOutput("s2 busy", 64'(sts_busy), 64'd0);
        checkDrained("s2 drained");

        // Backpressure: m_tready alternates, source advances only on handshakes.
        setCfg(4, 0, 1);
        startIdx = srcIdx;
        pushNoise(4);
        pushZero(1);
        fireTrigger();
        busyCnt = 0;
        for (int i = 0; i < 9; i++) begin
            m_axis_tready = (i % 2 == 0);
            @(negedge aclk);
            busyCnt += int'(sts_busy);
            if (i == 1) checkOutput("s3 s_tready stalled", 64'(s_axis_tready), 64'd0);
            tick();
        end
        m_axis_tready = 1'b0;
        checkOutput("s3 busy cycles", 64'(busyCnt), 64'd7);
        checkOutput("s3 source advance", 64'(srcIdx - startIdx), 64'd4);
        checkDrained("s3 drained");

        // Continuous mode, trigger ignored mid-burst, stop on the eighth beat.
        setCfg(2, 1, 0);
        pushNoise(2);
        pushZero(1);
        pushNoise(2);
        pushZero(1);
        pushNoise(2);
        pushZero(2);
        fireTrigger();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stop    = (i == 7);
            trigger = (i == 4);
            @(negedge aclk);
            if (i == 8) begin
                checkOutput("s4 busy after stop", 64'(sts_busy), 64'd0);
                checkOutput("s4 bursts after stop", 64'(sts_bursts), 64'd3);
            end
            tick();
        end
        stop          = 1'b0;
        trigger       = 1'b0;
        m_axis_tready = 1'b0;
        checkDrained("s4 drained");
        repeat (3) tick();
        @(negedge aclk);
        checkOutput("s4 bursts hold", 64'(sts_bursts), 64'd3);
        tick();
        fireTrigger();
        @(negedge aclk);
        checkOutput("s4 restart busy", 64'(sts_busy), 64'd1);
        checkOutput("s4 restart bursts", 64'(sts_bursts), 64'd0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge aclk);
        checkOutput("s4 stop in gapless", 64'(sts_busy), 64'd0);
        tick();

        // Zero burst length disarms the trigger.
        setCfg(0, 3, 1);
        fireTrigger();
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("s5 busy len0", 64'(sts_busy), 64'd0);
            tick();
        end

        // Reset asserted mid-sequence.
        setCfg(5, 0, 0);
        m_axis_tready = 1'b1;
        fireTrigger();
        @(negedge aclk);
        checkOutput("s6 busy", 64'(sts_busy), 64'd1);
        checkOutput("s6 s_tready", 64'(s_axis_tready), 64'd1);
        tick();
        aresetn = 1'b0;
        #1;
        checkOutput("s6 rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("s6 rst s_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("s6 rst busy", 64'(sts_busy), 64'd0);
        m_axis_tready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
